hilo_unit: RTL and testbench

- Owns the architectural HI/LO register pair and carries HI/LO writes from EX through MEM to WB. It sits directly downstream of the EX-stage ALU and consumes its 64-bit result and tohilo flag for MULT/MULTU/DIV/DIVU, plus MTHI/MTLO.
- Writes commit only at WB, so an exception in MEM cancels them.
- Supplies forwarded HI/LO values to EX so MFHI/MFLO read the correct value without stalling.

---
 rtl/hilo_pkg.sv | 21 ++
 rtl/hilo_stage_reg.sv | 31 +++
 rtl/hilo_unit.sv | 102 ++++++++++
 tb/tb_hilo_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO write pipeline: one in-flight HI/LO write
// and the empty (bubble) value that marks a stage with no write.
package hilo_pkg;

  localparam int HILO_WIDTH = 32;

  typedef struct packed {
    logic                  we_hi;
    logic                  we_lo;
    logic [HILO_WIDTH-1:0] hi;
    logic [HILO_WIDTH-1:0] lo;
  } hilo_wr_t;

  localparam hilo_wr_t HILO_BUBBLE = '{
    we_hi: 1'b0,
    we_lo: 1'b0,
    hi:    {HILO_WIDTH{1'b0}},
    lo:    {HILO_WIDTH{1'b0}}
  };

endpackage

// File: rtl/hilo_stage_reg.sv
// One pipeline stage holding a pending HI/LO write; bubble has priority
// over hold so a kill always empties the stage.
module hilo_stage_reg
  import hilo_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     hold,
  input  logic     bubble,
  input  hilo_wr_t d,
  output hilo_wr_t q
);

  hilo_wr_t q_r;

  // Stage register: async clear, then bubble / hold / load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= HILO_BUBBLE;
    end else if (bubble) begin
      q_r <= HILO_BUBBLE;
    end else if (hold) begin
      q_r <= q_r;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO pair with an EX->MEM->WB write pipeline that commits
// at WB, plus combinational forwarding of the newest pending value to EX.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int              WIDTH  = HILO_WIDTH,
  parameter logic [WIDTH-1:0] HI_RST = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] LO_RST = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               e_tohilo,
  input  logic               e_mthi,
  input  logic               e_mtlo,
  input  logic [2*WIDTH-1:0] e_ans,
  input  logic [WIDTH-1:0]   e_rs,
  input  logic               stall_e,
  input  logic               stall_m,
  input  logic               flush,
  output logic [WIDTH-1:0]   e_hi,
  output logic [WIDTH-1:0]   e_lo,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  hilo_wr_t ex_wr_s;
  hilo_wr_t m_wr_s;
  hilo_wr_t w_wr_s;
  logic     m_bubble_s;
  logic     m_hold_s;
  logic     w_bubble_s;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // EX decode: the ALU's tohilo result outranks MTHI/MTLO if both appear.
  always_comb begin
    ex_wr_s = HILO_BUBBLE;
    if (e_tohilo) begin
      ex_wr_s.we_hi = 1'b1;
      ex_wr_s.we_lo = 1'b1;
      ex_wr_s.hi    = e_ans[2*WIDTH-1:WIDTH];
      ex_wr_s.lo    = e_ans[WIDTH-1:0];
    end else if (e_mthi) begin
      ex_wr_s.we_hi = 1'b1;
      ex_wr_s.hi    = e_rs;
    end else if (e_mtlo) begin
      ex_wr_s.we_lo = 1'b1;
      ex_wr_s.lo    = e_rs;
    end else begin
      ex_wr_s = HILO_BUBBLE;
    end
  end

  // A stalled EX (e.g. divider busy) feeds bubbles so only the final cycle enters M.
  assign m_bubble_s = flush | (~stall_m & stall_e);
  assign m_hold_s   = stall_m;
  assign w_bubble_s = flush | stall_m;

  hilo_stage_reg u_stage_m (
    .clk    (clk),
    .rst    (rst),
    .hold   (m_hold_s),
    .bubble (m_bubble_s),
    .d      (ex_wr_s),
    .q      (m_wr_s)
  );

  hilo_stage_reg u_stage_w (
    .clk    (clk),
    .rst    (rst),
    .hold   (1'b0),
    .bubble (w_bubble_s),
    .d      (m_wr_s),
    .q      (w_wr_s)
  );

  // WB commit: W is older than any excepting instruction, so it always lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r <= HI_RST;
      lo_r <= LO_RST;
    end else begin
      if (w_wr_s.we_hi) begin
        hi_r <= w_wr_s.hi;
      end else begin
        hi_r <= hi_r;
      end
      if (w_wr_s.we_lo) begin
        lo_r <= w_wr_s.lo;
      end else begin
        lo_r <= lo_r;
      end
    end
  end

  assign hi_o = hi_r;
  assign lo_o = lo_r;

  assign e_hi = m_wr_s.we_hi ? m_wr_s.hi : (w_wr_s.we_hi ? w_wr_s.hi : hi_r);
  assign e_lo = m_wr_s.we_lo ? m_wr_s.lo : (w_wr_s.we_lo ? w_wr_s.lo : lo_r);

endmodule

// File: tb/tb_hilo_unit.sv
// Directed table-driven bench for hilo_unit plus a hand-written async reset sequence.
module tb_hilo_unit;

  localparam logic [31:0] H0 = 32'hDEAD_0000;
  localparam logic [31:0] L0 = 32'h0000_BEEF;

  logic        clk;
  logic        rst;
  logic        e_tohilo, e_mthi, e_mtlo;
  logic [63:0] e_ans;
  logic [31:0] e_rs;
  logic        stall_e, stall_m, flush;
  logic [31:0] e_hi, e_lo, hi_o, lo_o;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        tohilo;
    logic        mthi;
    logic        mtlo;
    logic [63:0] ans;
    logic [31:0] rs;
    logic        se;
    logic        sm;
    logic        fl;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vq[$];

  hilo_unit #(
    .WIDTH  (32),
    .HI_RST (H0),
    .LO_RST (L0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .e_tohilo (e_tohilo),
    .e_mthi   (e_mthi),
    .e_mtlo   (e_mtlo),
    .e_ans    (e_ans),
    .e_rs     (e_rs),
    .stall_e  (stall_e),
    .stall_m  (stall_m),
    .flush    (flush),
    .e_hi     (e_hi),
    .e_lo     (e_lo),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic [31:0] hi, input logic [31:0] lo);
    check({tag, ".e_hi"}, e_hi, ehi);
    check({tag, ".e_lo"}, e_lo, elo);
    check({tag, ".hi_o"}, hi_o, hi);
    check({tag, ".lo_o"}, lo_o, lo);
  endtask

  task automatic drive_idle();
    e_tohilo = 1'b0; e_mthi = 1'b0; e_mtlo = 1'b0;
    e_ans = 64'h0; e_rs = 32'h0;
    stall_e = 1'b0; stall_m = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    e_tohilo = v.tohilo; e_mthi = v.mthi; e_mtlo = v.mtlo;
    e_ans = v.ans; e_rs = v.rs;
    stall_e = v.se; stall_m = v.sm; flush = v.fl;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // Fields: tohilo mthi mtlo ans rs stall_e stall_m flush | e_hi e_lo hi_o lo_o after the edge
    // MULT -> forwarded from M, then W, then committed on the 3rd edge
    vq.push_back('{1'b1,1'b0,1'b0,64'h00000001_FFFFFFFE,32'h0,1'b0,1'b0,1'b0, 32'h1,32'hFFFFFFFE,H0,L0});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'h1,32'hFFFFFFFE,H0,L0});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'h1,32'hFFFFFFFE,32'h1,32'hFFFFFFFE});
    // MTHI then MTLO: mixed W/M forwarding
    vq.push_back('{1'b0,1'b1,1'b0,64'h0,32'hAAAA0000,1'b0,1'b0,1'b0, 32'hAAAA0000,32'hFFFFFFFE,32'h1,32'hFFFFFFFE});
    vq.push_back('{1'b0,1'b0,1'b1,64'h0,32'h00005555,1'b0,1'b0,1'b0, 32'hAAAA0000,32'h00005555,32'h1,32'hFFFFFFFE});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'hAAAA0000,32'h00005555,32'hAAAA0000,32'hFFFFFFFE});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'hAAAA0000,32'h00005555,32'hAAAA0000,32'h00005555});
    // DIV: tohilo 5 cycles, stall_e first 4 with junk ans
    vq.push_back('{1'b1,1'b0,1'b0,64'h12345678_9ABCDEF0,32'h0,1'b1,1'b0,1'b0, 32'hAAAA0000,32'h00005555,32'hAAAA0000,32'h00005555});
    vq.push_back('{1'b1,1'b0,1'b0,64'h12345678_9ABCDEF0,32'h0,1'b1,1'b0,1'b0, 32'hAAAA0000,32'h00005555,32'hAAAA0000,32'h00005555});
    vq.push_back('{1'b1,1'b0,1'b0,64'h12345678_9ABCDEF0,32'h0,1'b1,1'b0,1'b0, 32'hAAAA0000,32'h00005555,32'hAAAA0000,32'h00005555});
    vq.push_back('{1'b1,1'b0,1'b0,64'h12345678_9ABCDEF0,32'h0,1'b1,1'b0,1'b0, 32'hAAAA0000,32'h00005555,32'hAAAA0000,32'h00005555});
    vq.push_back('{1'b1,1'b0,1'b0,64'h00000003_0000000E,32'h0,1'b0,1'b0,1'b0, 32'h3,32'hE,32'hAAAA0000,32'h00005555});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'h3,32'hE,32'hAAAA0000,32'h00005555});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'h3,32'hE,32'h3,32'hE});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'h3,32'hE,32'h3,32'hE});
    // MULTU into M, then flushed
    vq.push_back('{1'b1,1'b0,1'b0,64'h11111111_22222222,32'h0,1'b0,1'b0,1'b0, 32'h11111111,32'h22222222,32'h3,32'hE});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b1, 32'h3,32'hE,32'h3,32'hE});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'h3,32'hE,32'h3,32'hE});
    // MTLO held in M by stall_m for 2 cycles
    vq.push_back('{1'b0,1'b0,1'b1,64'h0,32'h00001234,1'b0,1'b0,1'b0, 32'h3,32'h1234,32'h3,32'hE});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b1,1'b0, 32'h3,32'h1234,32'h3,32'hE});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b1,1'b0, 32'h3,32'h1234,32'h3,32'hE});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'h3,32'h1234,32'h3,32'hE});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'h3,32'h1234,32'h3,32'h1234});
    // Write in W still commits on flush; EX MTLO under flush is killed
    vq.push_back('{1'b0,1'b1,1'b0,64'h0,32'hCAFE0000,1'b0,1'b0,1'b0, 32'hCAFE0000,32'h1234,32'h3,32'h1234});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'hCAFE0000,32'h1234,32'h3,32'h1234});
    vq.push_back('{1'b0,1'b0,1'b1,64'h0,32'h00009999,1'b0,1'b0,1'b1, 32'hCAFE0000,32'h1234,32'hCAFE0000,32'h1234});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'hCAFE0000,32'h1234,32'hCAFE0000,32'h1234});
    // tohilo outranks mthi/mtlo
    vq.push_back('{1'b1,1'b1,1'b1,64'h00000007_00000008,32'hFFFFFFFF,1'b0,1'b0,1'b0, 32'h7,32'h8,32'hCAFE0000,32'h1234});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'h7,32'h8,32'hCAFE0000,32'h1234});
    vq.push_back('{1'b0,1'b0,1'b0,64'h0,32'h0,1'b0,1'b0,1'b0, 32'h7,32'h8,32'h7,32'h8});

    drive_idle();
    rst = 1'b0;
    #12;
    check_all("reset", H0, L0, H0, L0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive_vec(vq[i]);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vq[i].ehi, vq[i].elo, vq[i].hi, vq[i].lo);
    end

    // Async reset with pending MTHI in W and MTLO in M
    @(negedge clk);
    drive_idle();
    e_mthi = 1'b1; e_rs = 32'h0000_1111;
    @(negedge clk);
    drive_idle();
    e_mtlo = 1'b1; e_rs = 32'h0000_2222;
    @(posedge clk);
    #1;
    check_all("pre_rst", 32'h1111, 32'h2222, 32'h7, 32'h8);
    #2;
    drive_idle();
    rst = 1'b0;
    #1;
    check_all("async_rst", H0, L0, H0, L0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("post_rst%0d", k), H0, L0, H0, L0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
